// File: rtl/uc_pkg.sv
// Shared constants, state encoding and error codes for the unit-clause
// broadcast scheduler.
package uc_pkg;
  localparam int NUM_ENGINE = 4;
  localparam int LIT_W      = 11;
  localparam int MAX_UC     = 64;
  localparam int STALL_MAX  = 255;
  localparam int UC_CNT_W   = $clog2(MAX_UC) + 1;
  localparam int STALL_W    = $clog2(STALL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BCAST,
    S_DONE,
    S_ERROR
  } uc_bcast_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_STALL    = 2'd2;
  localparam logic [1:0] ERR_NO_ENG   = 2'd3;
endpackage

// File: rtl/uc_bcast_sched_if.sv
// Control, unit-clause queue and engine broadcast signals of uc_bcast_sched.
interface uc_bcast_sched_if;
  import uc_pkg::*;

  logic                  start;
  logic [NUM_ENGINE-1:0] eng_en;
  logic                  src_done;
  logic                  ucq_valid;
  logic [LIT_W-1:0]      ucq_lit;
  logic                  ucq_pop;
  logic [NUM_ENGINE-1:0] bc_valid;
  logic [LIT_W-1:0]      bc_lit;
  logic [NUM_ENGINE-1:0] eng_ready;
  logic [UC_CNT_W-1:0]   uc_count;
  logic                  busy;
  logic                  done;
  logic [1:0]            err;

  // Handshakes: engine i takes bc_lit in a cycle with bc_valid[i] && eng_ready[i];
  // until then bc_valid[i] and bc_lit hold. The queue is show-ahead: ucq_lit is
  // consumed in the same cycle ucq_pop pulses, and only while ucq_valid is high.
  modport master (
    output start, eng_en, src_done, ucq_valid, ucq_lit, eng_ready,
    input  ucq_pop, bc_valid, bc_lit, uc_count, busy, done, err
  );

  modport slave (
    input  start, eng_en, src_done, ucq_valid, ucq_lit, eng_ready,
    output ucq_pop, bc_valid, bc_lit, uc_count, busy, done, err
  );
endinterface

// File: rtl/uc_stall_timer.sv
// Counts consecutive broadcast cycles without any engine handshake.
module uc_stall_timer
  import uc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  logic [STALL_W-1:0] cnt;

  // Fires on the increment that would bring the count to STALL_MAX.
  assign expire = inc && (cnt == STALL_W'(STALL_MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uc_bcast_sched.sv
// Pops unit-clause literals one at a time and broadcasts each to every enabled
// BCP engine, waiting for all of them to accept before fetching the next.
module uc_bcast_sched
  import uc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  uc_bcast_sched_if.slave bus,
  output uc_bcast_state_t dbg_state
);
  uc_bcast_state_t       state;
  logic [NUM_ENGINE-1:0] en_r;
  logic [NUM_ENGINE-1:0] pending;
  logic [LIT_W-1:0]      lit_r;
  logic [UC_CNT_W-1:0]   uc_count;
  logic [1:0]            err;
  logic                  any_hs;
  logic                  last_hs;
  logic                  pop;
  logic                  stall_clr;
  logic                  stall_inc;
  logic                  stall_expire;

  // pending doubles as bc_valid, so eng_ready only reaches it through the flops.
  assign any_hs    = |(pending & bus.eng_ready);
  assign last_hs   = (pending & ~bus.eng_ready) == '0;
  assign pop       = (state == S_FETCH) && bus.ucq_valid &&
                     (uc_count != UC_CNT_W'(MAX_UC));
  assign stall_clr = pop || ((state == S_BCAST) && any_hs);
  assign stall_inc = (state == S_BCAST) && !any_hs;

  uc_stall_timer u_stall (
    .clk    (clk),
    .rst    (rst),
    .clr    (stall_clr),
    .inc    (stall_inc),
    .expire (stall_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      en_r     <= '0;
      pending  <= '0;
      lit_r    <= '0;
      uc_count <= '0;
      err      <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            en_r     <= bus.eng_en;
            uc_count <= '0;
            pending  <= '0;
            if (bus.eng_en == '0) begin
              state <= S_ERROR;
              err   <= ERR_NO_ENG;
            end else begin
              state <= S_FETCH;
              err   <= ERR_NONE;
            end
          end
        end
        S_FETCH: begin
          if (bus.ucq_valid) begin
            if (uc_count == UC_CNT_W'(MAX_UC)) begin
              state <= S_ERROR;
              err   <= ERR_OVERFLOW;
            end else begin
              lit_r   <= bus.ucq_lit;
              pending <= en_r;
              state   <= S_BCAST;
            end
          end else if (bus.src_done) begin
            state <= S_DONE;
          end
        end
        S_BCAST: begin
          if (last_hs) begin
            pending  <= '0;
            uc_count <= uc_count + 1'b1;
            state    <= S_FETCH;
          end else if (stall_expire) begin
            pending <= '0;
            state   <= S_ERROR;
            err     <= ERR_STALL;
          end else begin
            pending <= pending & ~bus.eng_ready;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ucq_pop  = pop;
  assign bus.bc_valid = pending;
  assign bus.bc_lit   = lit_r;
  assign bus.uc_count = uc_count;
  assign bus.busy     = (state == S_FETCH) || (state == S_BCAST);
  assign bus.done     = (state == S_DONE);
  assign bus.err      = err;
  assign dbg_state    = state;
endmodule

// File: doc/uc_bcast_sched.md
# uc_bcast_sched

Broadcast scheduler for unit-clause literals in the SAT-solver BCP datapath. Pops one literal at a time from the shared unit-clause queue and delivers it to every enabled BCP engine, holding each engine's valid until that engine accepts. Counts delivered literals, flags overflow and stalled engines, and signals completion once the upstream source is drained. Sits between the unit-clause queue output and the engine receive FIFOs.

## Interface
- NUM_ENGINE, 4, number of BCP engines.
- LIT_W, 11, literal width: bit LIT_W-1 = polarity, bits LIT_W-2:0 = variable index (1024 variables).
- MAX_UC, 64, maximum literals per phase; exceeding it is an error.
- STALL_MAX, 255, maximum consecutive BCAST cycles with no handshake before a stall error.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a phase, samples eng_en.
- eng_en  in  NUM_ENGINE  engines participating in this phase.
- src_done  in  1  upstream will push no more literals (level).
- ucq_valid  in  1  queue non-empty; ucq_lit valid (show-ahead).
- ucq_lit  in  LIT_W  head literal.
- ucq_pop  out  1  one-cycle pop pulse.
- bc_valid  out  NUM_ENGINE  per-engine offer valid.
- bc_lit  out  LIT_W  literal being broadcast, common to all engines.
- eng_ready  in  NUM_ENGINE  per-engine accept.
- uc_count  out  $clog2(MAX_UC)+1  literals fully delivered this phase.
- busy  out  1  state is not IDLE, DONE or ERROR.
- done  out  1  phase complete, held until next start.
- err  out  2  0 none, 1 overflow, 2 stall, 3 no engines enabled; held until next start.

## Operation
- States: IDLE, FETCH, BCAST, DONE, ERROR.
- IDLE: all outputs 0. start -> latch en_r = eng_en, clear uc_count, go FETCH; if eng_en == 0, go ERROR with err = 3.
- FETCH: if ucq_valid: if uc_count == MAX_UC -> ERROR, err = 1, no pop; else assert ucq_pop, capture lit_r = ucq_lit, pending = en_r, clear stall counter, go BCAST. Else if src_done -> DONE. Else stay.
- BCAST: bc_valid = pending, bc_lit = lit_r. An engine i with bc_valid[i] && eng_ready[i] in a cycle clears pending[i] at that edge. Multiple engines may hand shake in the same cycle. When every pending bit is cleared (including the same-cycle last handshakes), increment uc_count and go FETCH.
- Stall: counter increments on every BCAST cycle with no handshake and resets on any handshake. Reaching STALL_MAX -> ERROR, err = 2; bc_valid drops to 0.
- DONE / ERROR: bc_valid = 0, ucq_pop = 0; uc_count frozen. start re-enters as if from IDLE: clears done/err/uc_count and re-latches eng_en.
- start while busy is ignored. eng_en changes mid-phase are ignored.
- bc_lit is held stable while any bc_valid bit is set. Deasserting eng_ready never retracts an offer.
- Async reset mid-phase returns to IDLE immediately. All outputs drop to 0, and the popped literal is discarded.

## Timing
- Reset values: ucq_pop, bc_valid, bc_lit, uc_count, busy, done, err all 0.
- start at edge N -> busy at N+1; first ucq_pop no earlier than cycle N+1.
- ucq_pop in cycle F -> bc_valid = en_r in cycle F+1.
- Final handshake in cycle B -> uc_count updated and state FETCH at B+1; next pop no earlier than B+1. Peak throughput is one literal per 2 cycles.
- done rises the cycle after FETCH sees !ucq_valid && src_done.
- All outputs are registered or derived from state registers only; there is no combinational path from eng_ready to bc_valid.

## Structure
- Shared package uc_pkg holds the NUM_ENGINE, LIT_W and MAX_UC constants, the state enum uc_bcast_state_t, and the err code constants.
- One sub-module: uc_stall_timer (counter with clear, increment and expire-at-STALL_MAX).

## Test plan
- Reset, start with eng_en=4'b1111, push 3 literals (0x005, 0x40A, 0x3FF) with all ready high, then src_done -> each literal is offered for exactly 1 cycle to all engines; uc_count=3; done=1; err=0.
- Skewed ready: eng_ready bits rise at cycles +0, +2, +5, +1 respectively -> bc_lit stable and the pending bits clear one at a time; next ucq_pop occurs only after the cycle +5 handshake.
- eng_en=4'b0101 -> only bc_valid[0] and bc_valid[2] ever assert; ready on engines 1 and 3 is ignored.
- MAX_UC+1 literals queued -> after 64 deliveries, FETCH raises err=1 with no 65th pop; done=0.
- Engine 2 ready held low -> err=2 after STALL_MAX idle cycles; bc_valid=0; a later start recovers to a clean phase.
- Assert rst mid-BCAST, then release and start again -> outputs are 0 during reset, and the next phase begins from uc_count=0.
